store_buffer: RTL and testbench

//   Write-posting buffer directly upstream of the data memory in the MEM stage.

---
 rtl/store_buffer_pkg.sv | 20 ++
 rtl/sb_fifo.sv | 61 ++++++
 rtl/store_buffer.sv | 144 ++++++++++++++
 tb/tb_store_buffer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared data-memory access encodings and the store-buffer entry record.
// Entry layout, MSB first: {addr, data, type, pc}.
package store_buffer_pkg;

  localparam logic [2:0] dm_byte     = 3'b000;
  localparam logic [2:0] dm_halfword = 3'b001;
  localparam logic [2:0] dm_word     = 3'b010;

  localparam int SB_TYPE_W = 3;
  localparam int SB_PC_W   = 32;

  function automatic int sb_ent_w(input int aw, input int dw);
    return aw + dw + SB_TYPE_W + SB_PC_W;
  endfunction

  localparam int SB_ENT_W = sb_ent_w(32, 32);

  typedef logic [SB_ENT_W-1:0] sb_ent_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular entry storage for the store buffer.
// Tracks head/tail pointers, occupancy and per-entry valid bits.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [DEPTH-1:0][W-1:0]   ent,
  output logic [DEPTH-1:0]          vld,
  output logic [PW-1:0]             head,
  output logic [PW-1:0]             tail,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      empty
);

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      ent[tail_q] <= din;
    end
  end

  assign vld   = vld_q;
  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// MEM-stage write-posting store buffer with load-conflict stalling.
// Optional SB_LD_FWD_EN: forward full-word hits to loads instead of stalling.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [2:0]    st_type,
  input  logic [31:0]   st_pc,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_stall,
`ifdef SB_LD_FWD_EN
  output logic          ld_fwd_hit,
  output logic [DW-1:0] ld_fwd_data,
`endif
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic [2:0]    dm_type,
  output logic [31:0]   dm_pc,
  output logic          sb_empty,
  output logic [CW-1:0] sb_count
);

  localparam int EW    = sb_ent_w(AW, DW);
  localparam int PC_LO = 0;
  localparam int TY_LO = PC_LO + SB_PC_W;
  localparam int DA_LO = TY_LO + SB_TYPE_W;
  localparam int AD_LO = DA_LO + DW;

  logic [DEPTH-1:0][EW-1:0] ent;
  logic [DEPTH-1:0]         vld;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic [EW-1:0]            din;
  logic [EW-1:0]            hd;
  logic [DEPTH-1:0]         match;
  logic                     fwd_hit;

  assign din  = {st_addr, st_data, st_type, st_pc};
  assign push = st_valid & st_ready;
  assign pop  = dm_wr;

  sb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .ent   (ent),
    .vld   (vld),
    .head  (head),
    .tail  (tail),
    .count (sb_count),
    .full  (full),
    .empty (empty)
  );

  assign st_ready = ~full;
  assign sb_empty = empty;
  assign hd       = ent[head];

  // Word-granular CAM over index bits [11:2].
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld[i] & (ent[i][AD_LO+2 +: 10] == ld_addr[11:2]);
    end
  end

`ifdef SB_LD_FWD_EN
  logic [EW-1:0] yng;
  logic          found;
  logic [PW-1:0] idx;

  // Walk from the newest entry back to the oldest.
  always_comb begin
    yng   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(1) - PW'(i);
      if (!found && match[idx]) begin
        found = 1'b1;
        yng   = ent[idx];
      end
    end
  end

  assign fwd_hit = ld_valid & found
                 & (yng[TY_LO +: SB_TYPE_W] == dm_word)
                 & (yng[AD_LO+2 +: AW-2] == ld_addr[AW-1:2]);

  assign ld_fwd_hit  = fwd_hit;
  assign ld_fwd_data = fwd_hit ? yng[DA_LO +: DW] : '0;
`else
  logic sb_unused_tail;

  assign fwd_hit        = 1'b0;
  assign sb_unused_tail = ^tail;
`endif

  assign ld_stall = ld_valid & (|match) & ~fwd_hit;

  // A stalled load frees the bus, so draining always makes progress.
  assign dm_wr = ~empty & (~ld_valid | ld_stall);

  always_comb begin
    dm_addr = ld_addr;
    dm_din  = '0;
    dm_type = '0;
    dm_pc   = '0;
    unique case (1'b1)
      dm_wr: begin
        dm_addr = hd[AD_LO +: AW];
        dm_din  = hd[DA_LO +: DW];
        dm_type = hd[TY_LO +: SB_TYPE_W];
        dm_pc   = hd[PC_LO +: SB_PC_W];
      end
      default: begin
        dm_addr = ld_addr;
      end
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model.
// Define SB_LD_FWD_EN to also cover load forwarding.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_type;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
`ifdef SB_LD_FWD_EN
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
`endif
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic [31:0] dm_pc;
  logic        sb_empty;
  logic [2:0]  sb_count;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_type     (st_type),
    .st_pc       (st_pc),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_stall    (ld_stall),
`ifdef SB_LD_FWD_EN
    .ld_fwd_hit  (ld_fwd_hit),
    .ld_fwd_data (ld_fwd_data),
`endif
    .dm_wr       (dm_wr),
    .dm_addr     (dm_addr),
    .dm_din      (dm_din),
    .dm_type     (dm_type),
    .dm_pc       (dm_pc),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  ent_t        nxt;
  bit          m_pop = 0;
  bit          m_push = 0;
  logic [31:0] mem_ref[logic [31:0]];
  logic [31:0] mem_dut[logic [31:0]];

  // Model: pending stores in program order; expectations from the rules.
  always @(negedge clk) begin
    bit any;
    bit hit;
    bit e_stall;
    bit e_wr;
    int yidx;
    if (!rst) begin
      any  = 0;
      hit  = 0;
      yidx = -1;
      foreach (q[i]) begin
        if (q[i].addr[11:2] == ld_addr[11:2]) begin
          any  = 1;
          yidx = i;
        end
      end
`ifdef SB_LD_FWD_EN
      if (ld_valid && yidx >= 0)
        hit = (q[yidx].typ == dm_word) &&
              (q[yidx].addr[31:2] == ld_addr[31:2]);
      chk("cyc_fwd_hit", ld_fwd_hit, hit);
      if (hit) chk("cyc_fwd_data", ld_fwd_data, q[yidx].data);
`endif
      e_stall = ld_valid && any && !hit;
      e_wr    = (q.size() > 0) && (!ld_valid || e_stall);
      chk("cyc_ready", st_ready, q.size() != 4);
      chk("cyc_empty", sb_empty, q.size() == 0);
      chk("cyc_count", sb_count, q.size());
      chk("cyc_stall", ld_stall, e_stall);
      chk("cyc_wr", dm_wr, e_wr);
      if (e_wr) begin
        chk("cyc_addr", dm_addr, q[0].addr);
        chk("cyc_din", dm_din, q[0].data);
        chk("cyc_type", dm_type, q[0].typ);
        chk("cyc_pc", dm_pc, q[0].pc);
      end else begin
        chk("cyc_addr_ld", dm_addr, ld_addr);
        chk("cyc_din_0", dm_din, 0);
      end
      if (dm_wr) mem_dut[dm_addr] = dm_din;
      m_pop  = e_wr;
      m_push = st_valid && (q.size() != 4);
      nxt    = '{st_addr, st_data, st_type, st_pc};
      if (m_push) mem_ref[st_addr] = st_data;
    end else begin
      m_pop  = 0;
      m_push = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(nxt);
    end
    m_pop  = 0;
    m_push = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] t, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_type  = t;
    st_pc    = pc;
  endtask

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_type  = dm_word;
    st_pc    = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    #2;
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", sb_empty, 1);
    chk("rst_wr", dm_wr, 0);
    chk("rst_stall", ld_stall, 0);
    chk("rst_count", sb_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word store drains the cycle after acceptance
    step();
    put(32'h100, 32'hDEADBEEF, dm_word, 32'h80);
    step();
    st_valid = 1'b0;
    @(negedge clk);
    chk("sw_wr", dm_wr, 1);
    chk("sw_addr", dm_addr, 32'h100);
    chk("sw_din", dm_din, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("sw_empty", sb_empty, 1);

    // Fill while a non-conflicting load owns the bus
    step();
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    for (int i = 0; i < 4; i++) begin
      put(32'h400 + 4 * i, 32'hC0DE0000 + i, dm_word, 32'h1000 + 4 * i);
      step();
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("fill_count", sb_count, 4);
    chk("fill_ready", st_ready, 0);
    chk("fill_wr", dm_wr, 0);
    chk("fill_addr", dm_addr, 32'h200);
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_wr", dm_wr, 1);
      chk("burst_addr", dm_addr, 32'h400 + 4 * i);
      chk("burst_din", dm_din, 32'hC0DE0000 + i);
    end
    step();
    @(negedge clk);
    chk("burst_empty", sb_empty, 1);

    // Byte store then a load to the same word
    step();
    put(32'h104, 32'h55, dm_byte, 32'h2000);
    step();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h106;
    @(negedge clk);
    chk("raw_stall", ld_stall, 1);
    chk("raw_wr", dm_wr, 1);
    chk("raw_addr", dm_addr, 32'h104);
    step();
    @(negedge clk);
    chk("raw_release", ld_stall, 0);
    chk("raw_wr_off", dm_wr, 0);
    chk("raw_ld_addr", dm_addr, 32'h106);
    step();
    ld_valid = 1'b0;

    // Preload two, then enqueue and drain every cycle across wraps
    ld_valid = 1'b1;
    ld_addr  = 32'h800;
    put(32'h700, 32'h11111111, dm_word, 32'h3000);
    step();
    put(32'h704, 32'h22222222, dm_word, 32'h3004);
    step();
    chk("pre_count", sb_count, 2);
    ld_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      put(32'h500 + 4 * (i % 6), 32'hA0000000 + i, dm_word, 32'h4000 + 4 * i);
      step();
      chk("steady_count", sb_count, 2);
    end
    st_valid = 1'b0;
    for (int k = 0; k < 12 && !sb_empty; k++) step();
    chk("drain_done", sb_empty, 1);
    @(negedge clk);
    chk("mem_500", mem_dut.exists(32'h500) ? mem_dut[32'h500] : 'x,
        32'hA0000012);
    foreach (mem_ref[a])
      chk("mem", mem_dut.exists(a) ? mem_dut[a] : 'x, mem_ref[a]);

`ifdef SB_LD_FWD_EN
    step();
    put(32'h300, 32'h12345678, dm_word, 32'h5000);
    step();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h300;
    @(negedge clk);
    chk("fwd_stall", ld_stall, 0);
    chk("fwd_hit", ld_fwd_hit, 1);
    chk("fwd_data", ld_fwd_data, 32'h12345678);
    chk("fwd_wr", dm_wr, 0);
    step();
    ld_valid = 1'b0;
    step();
    step();
    put(32'h300, 32'h1234, dm_halfword, 32'h5004);
    step();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    @(negedge clk);
    chk("sh_stall", ld_stall, 1);
    chk("sh_nohit", ld_fwd_hit, 0);
    step();
    ld_valid = 1'b0;
    step();
    step();
`endif

    // Asynchronous reset with a pending entry discards it
    step();
    ld_valid = 1'b1;
    ld_addr  = 32'h900;
    put(32'h600, 32'hBADBAD00, dm_word, 32'h6000);
    step();
    st_valid = 1'b0;
    step();
    chk("pend_count", sb_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", st_ready, 1);
    chk("arst_empty", sb_empty, 1);
    chk("arst_wr", dm_wr, 0);
    chk("arst_count", sb_count, 0);
    ld_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("arst_no_write", mem_dut.exists(32'h600), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
